// File: rtl/gcd_requester.sv
// gcd_requester: queues operand pairs from upstream, feeds them one at a time
// to an external GCD unit, waits for each result (with a timeout), and
// presents results downstream through a single output register.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and data is stable while valid.
// The GCD side uses gcd_data_rdy as a one-cycle request strobe and
// gcd_result_taken as a one-cycle consume strobe for gcd_result_rdy/data.
module gcd_requester #(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         gcd_data_rdy,
  output logic [W-1:0] gcd_operands_A,
  output logic [W-1:0] gcd_operands_B,
  input  logic         gcd_result_rdy,
  input  logic [W-1:0] gcd_result_data,
  output logic         gcd_result_taken,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         timeout_err,
  output logic [15:0]  done_count,
  output logic [1:0]   state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   mem_a [DEPTH];
  logic [W-1:0]   mem_b [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           full, empty, push, pop, take, tmo_hit;
  logic [TW-1:0]  timer;

  // FIFO status from pointers with one wrap bit
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = in_valid && in_ready;

  // Result accepted from the GCD unit only when the output register can take it
  assign take    = (state == S_WAIT) && gcd_result_rdy && (!out_valid || out_ready);
  // The timer value seen here is one behind the count including this cycle
  assign tmo_hit = (state == S_WAIT) && !gcd_result_rdy && (timer == TW'(TIMEOUT - 2));

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (take)         state_nxt = S_IDLE;
        else if (tmo_hit) state_nxt = S_ERR;
      end
      default: state_nxt = S_ERR;
    endcase
  end

  // FSM outputs and FIFO pop decode
  always_comb begin
    in_ready         = !full && (state != S_ERR);
    gcd_data_rdy     = (state == S_ISSUE);
    gcd_result_taken = take;
    pop              = (state == S_ISSUE) && !empty;
    busy             = (state != S_IDLE) || !empty;
    state_dbg        = state;
    gcd_operands_A   = '0;
    gcd_operands_B   = '0;
    if (!empty) begin
      gcd_operands_A = mem_a[rd_ptr[AW-1:0]];
      gcd_operands_B = mem_b[rd_ptr[AW-1:0]];
    end
  end

  // FIFO storage (contents need no reset; pointers gate visibility)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr[AW-1:0]] <= in_a;
      mem_b[wr_ptr[AW-1:0]] <= in_b;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Wait timer: cleared on issue, counts only cycles with no result offered
  always_ff @(posedge clk) begin
    if (reset)                                    timer <= '0;
    else if (state == S_ISSUE)                    timer <= '0;
    else if ((state == S_WAIT) && !gcd_result_rdy) timer <= timer + TW'(1);
  end

  // Output register, sticky timeout flag and completion counter
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      timeout_err <= 1'b0;
      done_count  <= '0;
    end else begin
      if (take) begin
        out_valid  <= 1'b1;
        out_data   <= gcd_result_data;
        done_count <= done_count + 16'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: behavioural GCD unit, expected-result scoreboard,
// one task per scenario.
module tb_gcd_requester;
  localparam int W       = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         gcd_data_rdy;
  logic [W-1:0] gcd_operands_A, gcd_operands_B;
  logic         gcd_result_rdy = 1'b0;
  logic [W-1:0] gcd_result_data = '0;
  logic         gcd_result_taken;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy, timeout_err;
  logic [15:0]  done_count;
  logic [1:0]   state_dbg;

  gcd_requester #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .gcd_data_rdy(gcd_data_rdy), .gcd_operands_A(gcd_operands_A), .gcd_operands_B(gcd_operands_B),
    .gcd_result_rdy(gcd_result_rdy), .gcd_result_data(gcd_result_data),
    .gcd_result_taken(gcd_result_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err), .done_count(done_count), .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]   exp_q[$];   // expected results in delivery order
  logic [2*W-1:0] iss_q[$];   // expected operand pairs in issue order
  int n_taken = 0;
  int n_pushed = 0;           // pairs accepted since the last reset
  int or_mode = 0;            // 0: out_ready low, 1: high, 2: random
  bit gcd_mute = 1'b0;        // GCD unit never answers when set

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // ---------------- behavioural GCD unit ----------------
  bit           m_pend = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_res = '0;
  logic         m_rdy_n;
  logic [W-1:0] m_dat_n;
  always @(posedge clk) begin
    m_rdy_n = gcd_result_rdy;
    m_dat_n = gcd_result_data;
    if (reset) begin
      m_rdy_n = 1'b0;
      m_pend  = 1'b0;
    end else begin
      if (gcd_result_rdy && gcd_result_taken) m_rdy_n = 1'b0;
      if (m_pend) begin
        if (m_cnt == 0) begin
          m_rdy_n = 1'b1; m_dat_n = m_res; m_pend = 1'b0;
        end else m_cnt--;
      end
      if (gcd_data_rdy && !gcd_mute) begin
        m_pend = 1'b1;
        m_cnt  = $urandom_range(0, 3);
        m_res  = ref_gcd(gcd_operands_A, gcd_operands_B);
      end
    end
    #1;
    gcd_result_rdy  = m_rdy_n;
    gcd_result_data = m_dat_n;
  end

  // Downstream ready driver
  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard / monitors ----------------
  always @(posedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_extra: got %0d, expected no result", out_data);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data: got %0d, expected %0d", out_data, e);
          end
        end
      end
      if (gcd_data_rdy) begin
        checks++;
        if (iss_q.size() == 0) begin
          errors++;
          $display("FAIL issue_extra: got A=%0d B=%0d, expected no request", gcd_operands_A, gcd_operands_B);
        end else begin
          logic [2*W-1:0] p;
          p = iss_q.pop_front();
          if ({gcd_operands_A, gcd_operands_B} !== p) begin
            errors++;
            $display("FAIL issue_ops: got A=%0d B=%0d, expected A=%0d B=%0d",
                     gcd_operands_A, gcd_operands_B, p[2*W-1:W], p[W-1:0]);
          end
        end
      end
      if (gcd_result_taken) n_taken++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    exp_q.delete(); iss_q.delete();
    n_pushed = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    int guard;
    acc = 1'b0; guard = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        exp_q.push_back(ref_gcd(a, b));
        iss_q.push_back({a, b});
        n_pushed++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_accept: got in_ready=0 for 200 cycles, expected acceptance");
    end
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 2000) begin
      errors++;
      $display("FAIL %s_drain: got %0d results outstanding, expected 0", name, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)        begin errors++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0)       begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    checks++; if (out_data !== '0)          begin errors++; $display("FAIL rst_out_data: got %0d, expected 0", out_data); end
    checks++; if (timeout_err !== 1'b0)     begin errors++; $display("FAIL rst_timeout_err: got %b, expected 0", timeout_err); end
    checks++; if (done_count !== 16'd0)     begin errors++; $display("FAIL rst_done_count: got %0d, expected 0", done_count); end
    checks++; if (gcd_data_rdy !== 1'b0)    begin errors++; $display("FAIL rst_data_rdy: got %b, expected 0", gcd_data_rdy); end
    checks++; if (gcd_result_taken !== 1'b0) begin errors++; $display("FAIL rst_taken: got %b, expected 0", gcd_result_taken); end
    checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    checks++;
    if (gcd_operands_A !== '0 || gcd_operands_B !== '0) begin
      errors++; $display("FAIL rst_operands: got A=%0d B=%0d, expected 0 0", gcd_operands_A, gcd_operands_B);
    end
  endtask

  task automatic test_basic();
    do_reset();
    gcd_mute = 1'b0; or_mode = 1;
    push(16'd12, 16'd8);
    @(negedge clk);
    checks++; if (gcd_data_rdy !== 1'b0) begin errors++; $display("FAIL lat_early: got data_rdy=%b, expected 0", gcd_data_rdy); end
    @(negedge clk);
    checks++; if (gcd_data_rdy !== 1'b1) begin errors++; $display("FAIL lat_issue: got data_rdy=%b, expected 1", gcd_data_rdy); end
    @(negedge clk);
    checks++; if (gcd_data_rdy !== 1'b0) begin errors++; $display("FAIL lat_pulse: got data_rdy=%b, expected 0", gcd_data_rdy); end
    begin
      int g;
      g = 0;
      while (!out_valid && g < 50) begin @(negedge clk); g++; end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b, expected 1", out_valid); end
    checks++; if (out_data !== 16'd4) begin errors++; $display("FAIL basic_data: got %0d, expected 4", out_data); end
    checks++; if (done_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d, expected 1", done_count); end
    wait_drain("basic");
  endtask

  task automatic test_order();
    int t0;
    do_reset();
    gcd_mute = 1'b0; or_mode = 1;
    t0 = n_taken;
    push(16'd0, 16'd5);
    push(16'd7, 16'd0);
    wait_drain("order");
    checks++;
    if (n_taken - t0 != 2) begin errors++; $display("FAIL order_taken: got %0d pulses, expected 2", n_taken - t0); end
  endtask

  task automatic test_backpressure();
    do_reset();
    gcd_mute = 1'b0; or_mode = 0;
    push(16'd12, 16'd8);
    push(16'd9, 16'd6);
    repeat (20) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd4) begin errors++; $display("FAIL bp_hold: got valid=%b data=%0d, expected 1 4", out_valid, out_data); end
    checks++; if (gcd_result_rdy !== 1'b1 || gcd_result_taken !== 1'b0) begin errors++; $display("FAIL bp_taken: got rdy=%b taken=%b, expected 1 0", gcd_result_rdy, gcd_result_taken); end
    checks++; if (done_count !== 16'd1) begin errors++; $display("FAIL bp_count1: got %0d, expected 1", done_count); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b, expected 0", timeout_err); end
    or_mode = 1;
    wait_drain("bp");
    checks++; if (done_count !== 16'd2) begin errors++; $display("FAIL bp_count2: got %0d, expected 2", done_count); end
  endtask

  task automatic test_full();
    int acc;
    do_reset();
    gcd_mute = 1'b1; or_mode = 1;
    acc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = W'(i + 1); in_b = W'(10 * i + 3);
      @(negedge clk);
      if (in_ready) begin
        acc++;
        iss_q.push_back({in_a, in_b});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (acc != 5) begin errors++; $display("FAIL full_accepted: got %0d, expected 5", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b, expected 0", in_ready); end
    checks++; if (iss_q.size() != 4) begin errors++; $display("FAIL full_issued: got %0d queued, expected 4", iss_q.size()); end
  endtask

  task automatic test_timeout();
    int g;
    do_reset();
    gcd_mute = 1'b1; or_mode = 1;
    push(16'd3, 16'd9);
    g = 0;
    do begin @(negedge clk); g++; end while (!gcd_data_rdy && g < 10);
    checks++; if (gcd_data_rdy !== 1'b1) begin errors++; $display("FAIL tmo_issue: got data_rdy=%b, expected 1", gcd_data_rdy); end
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == TIMEOUT - 1) begin
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b at %0d cycles, expected 0", timeout_err, k); end
      end
    end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b, expected 1", timeout_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL tmo_in_ready: got %b, expected 0", in_ready); end
    repeat (5) @(negedge clk);
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got err=%b busy=%b, expected 1 1", timeout_err, busy); end
    test_reset();
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    do_reset();
    gcd_mute = 1'b1; or_mode = 1;
    push(16'd4, 16'd6);
    push(16'd10, 16'd15);
    push(16'd8, 16'd12);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, expected 1", busy); end
    do_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_cleared: got busy=%b valid=%b in_ready=%b, expected 0 0 1", busy, out_valid, in_ready);
    end
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (gcd_data_rdy) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL mid_no_issue: got data_rdy=1, expected 0"); end
    gcd_mute = 1'b0;
    push(16'd21, 16'd14);
    wait_drain("mid");
    checks++; if (done_count !== 16'd1) begin errors++; $display("FAIL mid_count: got %0d, expected 1", done_count); end
  endtask

  task automatic test_random();
    int t0;
    do_reset();
    gcd_mute = 1'b0; or_mode = 2;
    t0 = n_taken;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] k, a, b;
      k = W'($urandom_range(1, 12));
      a = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 60)) * k;
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 60)) * k;
      push(a, b);
    end
    wait_drain("rand");
    checks++; if (done_count !== 16'(n_pushed)) begin errors++; $display("FAIL rand_count: got %0d, expected %0d", done_count, n_pushed); end
    checks++; if (n_taken - t0 != n_pushed) begin errors++; $display("FAIL rand_taken: got %0d, expected %0d", n_taken - t0, n_pushed); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rand_timeout: got %b, expected 0", timeout_err); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_order();
    test_backpressure();
    test_full();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_requester.md
GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 Parameters: W, default 16, operand/result width; DEPTH, default 4, request FIFO entries (power of 2, >=2); TIMEOUT, default 1024, max cycles to wait for a result.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream operand pair valid.
REQ-005 in_ready  output  1  request FIFO can accept a pair.
REQ-006 in_a, in_b  input  W each  upstream operands.
REQ-007 gcd_data_rdy  output  1  request strobe to GCD unit.
REQ-008 gcd_operands_A, gcd_operands_B  output  W each  operands to GCD unit.
REQ-009 gcd_result_rdy  input  1  GCD result available.
REQ-010 gcd_result_data  input  W  GCD result value.
REQ-011 gcd_result_taken  output  1  result consumed strobe to GCD unit.
REQ-012 out_valid  output  1  result register holds a result.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_data  output  W  result value.
REQ-015 busy  output  1  high when FSM not in IDLE or FIFO non-empty.
REQ-016 timeout_err  output  1  sticky timeout flag.
REQ-017 done_count  output  16  completed transactions, wraps 0xFFFF->0.

Function
REQ-018 FIFO: push when in_valid && in_ready; in_ready = !full; pops only in ISSUE; FIFO order preserved; no push while full; no pop while empty.
REQ-019 FSM states IDLE, ISSUE, WAIT, ERR.
REQ-020 IDLE: FIFO non-empty -> ISSUE next cycle; otherwise stay.
REQ-021 ISSUE: gcd_data_rdy=1 for exactly this cycle; gcd_operands_A/B = FIFO head; head popped at end of cycle; timer cleared; -> WAIT.
REQ-022 gcd_operands_A/B equal the FIFO head whenever FIFO non-empty and are 0 when empty; gcd_data_rdy=0 in every state other than ISSUE.
REQ-023 WAIT: if gcd_result_rdy && (!out_valid || out_ready): gcd_result_taken=1 combinationally this cycle, out_data <= gcd_result_data, out_valid <= 1, done_count += 1, -> IDLE.
REQ-024 WAIT with gcd_result_rdy=1 but out_valid=1 && out_ready=0: gcd_result_taken=0; stay in WAIT (backpressure holds the GCD unit in its result state); timer does not advance.
REQ-025 WAIT timer increments each cycle gcd_result_rdy=0; when it reaches TIMEOUT-1 with no result -> ERR, timeout_err <= 1.
REQ-026 ERR: in_ready=0, gcd_data_rdy=0, gcd_result_taken=0; exits only on reset; out register still drains via out_ready.
REQ-027 gcd_result_taken is never high outside WAIT and is high for at most one cycle per transaction.
REQ-028 Output register: out_valid clears on out_valid && out_ready unless reloaded the same cycle (REQ-023), in which case out_valid stays 1 with the new data.
REQ-029 At most one GCD transaction outstanding; the next gcd_data_rdy is no earlier than 2 cycles after gcd_result_taken.
REQ-030 Latency: a pair pushed at edge t with an idle FSM and empty FIFO gives gcd_data_rdy high in the cycle following edge t+1.

Reset
REQ-031 On reset: FSM=IDLE, FIFO empty, timer=0, out_valid=0, out_data=0, timeout_err=0, done_count=0, gcd_data_rdy=0, gcd_result_taken=0, in_ready=1 (the cycle after reset deasserts).
REQ-032 Reset in any state, including mid-WAIT, discards queued and in-flight requests; the GCD unit is reset by the same reset.

Verification
REQ-033 Push (12,8) with out_ready=1 -> one gcd_data_rdy pulse with A=12, B=8; out_data=4, out_valid=1; done_count=1.
REQ-034 Push (0,5) then (7,0) -> out_data 5 then 7 in order; exactly two gcd_result_taken pulses.
REQ-035 out_ready=0, push (12,8),(9,6) -> first result 4 held; second transaction stays in WAIT with gcd_result_taken=0; raise out_ready -> 3 delivered; done_count=2.
REQ-036 GCD model holds gcd_result_rdy=0, push 6 pairs -> one pair issued, 4 queued, in_ready=0 after 5 accepted pushes; the sixth pair is not accepted.
REQ-037 GCD model never responds -> timeout_err=1 exactly TIMEOUT cycles after ISSUE; in_ready=0; reset clears all outputs per REQ-031.
REQ-038 Reset asserted mid-WAIT with 2 pairs queued -> FIFO empty, out_valid=0, no gcd_data_rdy until a new push.
